// File: rtl/kbd_ctrl_decoder.sv
// PS/2 set-2 scancode decoder: prefix tracking, joystick key state, video hotkeys
// and a stretched core reset, all in the clk domain with registered outputs.
module kbd_ctrl_decoder #(
  parameter int unsigned RESET_HOLD   = 16,
  parameter logic        SCANDBL_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_intr,
  input  logic [7:0] kbd_scancode,
  output logic [8:0] joyBCPPFRLDU,
  output logic       scandoubler_disable_o,
  output logic [1:0] scanlines_o,
  output logic       rst_core_o
);

  localparam int unsigned CNT_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(RESET_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic             intr_q, intr_d;
  logic             arm_q, arm_d;
  logic [8:0]       joy_q, joy_d;
  logic [2:0]       held_q, held_d;
  logic             sd_q, sd_d;
  logic [1:0]       sl_q, sl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       byte_ev;
  logic       key_ext;
  logic       key_brk;
  logic       do_key;
  logic [8:0] joy_sel;
  logic [2:0] hot_sel;
  logic [2:0] hot_fire;

  // Extended/break qualifiers come straight from the registered prefix state.
  assign key_ext = (state_q == S_EXT) || (state_q == S_EXTBRK);
  assign key_brk = (state_q == S_BRK) || (state_q == S_EXTBRK);

  always_comb begin
    joy_sel = '0;
    hot_sel = '0;
    if (key_ext) begin
      case (kbd_scancode)
        8'h75:   joy_sel[0] = 1'b1;
        8'h72:   joy_sel[1] = 1'b1;
        8'h6B:   joy_sel[2] = 1'b1;
        8'h74:   joy_sel[3] = 1'b1;
        default: ;
      endcase
    end else begin
      case (kbd_scancode)
        8'h29:   joy_sel[4] = 1'b1;
        8'h16:   joy_sel[5] = 1'b1;
        8'h1E:   joy_sel[6] = 1'b1;
        8'h2E:   joy_sel[7] = 1'b1;
        8'h11:   joy_sel[8] = 1'b1;
        8'h06:   hot_sel[0] = 1'b1;
        8'h04:   hot_sel[1] = 1'b1;
        8'h07:   hot_sel[2] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    joy_d    = joy_q;
    held_d   = held_q;
    sd_d     = sd_q;
    sl_d     = sl_q;
    cnt_d    = cnt_q;
    do_key   = 1'b0;
    hot_fire = '0;
    intr_d   = kbd_intr;
    // A strobe already high when reset released must drop once before it counts.
    arm_d    = arm_q | ~kbd_intr;
    byte_ev  = kbd_intr & ~intr_q & arm_q;

    if (byte_ev) begin
      case (state_q)
        S_IDLE: begin
          if (kbd_scancode == 8'hE0) begin
            state_d = S_EXT;
          end else if (kbd_scancode == 8'hF0) begin
            state_d = S_BRK;
          end else if (kbd_scancode == 8'hE1) begin
            state_d = S_PAUSE;
            skip_d  = 3'd7;
          end else begin
            do_key = 1'b1;
          end
        end
        S_EXT: begin
          if (kbd_scancode == 8'hF0) begin
            state_d = S_EXTBRK;
          end else if (kbd_scancode != 8'hE0) begin
            do_key  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK, S_EXTBRK: begin
          do_key  = 1'b1;
          state_d = S_IDLE;
        end
        S_PAUSE: begin
          skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_key) begin
      if (key_brk) begin
        joy_d  = joy_q & ~joy_sel;
        held_d = held_q & ~hot_sel;
      end else begin
        joy_d    = joy_q | joy_sel;
        hot_fire = hot_sel & ~held_q;
        held_d   = held_q | hot_sel;
      end
    end

    if (hot_fire[0]) begin
      sd_d = ~sd_q;
    end
    if (hot_fire[1]) begin
      sl_d = sl_q + 2'd1;
    end

    if (hot_fire[2]) begin
      cnt_d = HOLD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
      intr_q  <= 1'b0;
      arm_q   <= ~kbd_intr;
      joy_q   <= '0;
      held_q  <= '0;
      sd_q    <= SCANDBL_INIT;
      sl_q    <= 2'd0;
      cnt_q   <= HOLD_VAL;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      intr_q  <= intr_d;
      arm_q   <= arm_d;
      joy_q   <= joy_d;
      held_q  <= held_d;
      sd_q    <= sd_d;
      sl_q    <= sl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign joyBCPPFRLDU          = joy_q;
  assign scandoubler_disable_o = sd_q;
  assign scanlines_o           = sl_q;
  assign rst_core_o            = (cnt_q != '0);

endmodule

// File: tb/tb_kbd_ctrl_decoder.sv
// Scoreboard bench for kbd_ctrl_decoder: stimulus pushes expected state per byte,
// a monitor pops on every strobe event and also checks rst_core_o every cycle.
module tb_kbd_ctrl_decoder;

  localparam int   HOLD = 16;
  localparam logic INIT = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kbd_intr = 1'b0;
  logic [7:0] kbd_scancode = 8'h00;
  logic [8:0] joyBCPPFRLDU;
  logic       scandoubler_disable_o;
  logic [1:0] scanlines_o;
  logic       rst_core_o;

  kbd_ctrl_decoder #(.RESET_HOLD(HOLD), .SCANDBL_INIT(INIT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .kbd_intr              (kbd_intr),
    .kbd_scancode          (kbd_scancode),
    .joyBCPPFRLDU          (joyBCPPFRLDU),
    .scandoubler_disable_o (scandoubler_disable_o),
    .scanlines_o           (scanlines_o),
    .rst_core_o            (rst_core_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [8:0] joy;
    logic       sd;
    logic [1:0] sl;
    bit         reload;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: key state and prefix bookkeeping from the protocol rules.
  logic [8:0] m_joy;
  logic       m_sd;
  logic [1:0] m_sl;
  bit         m_held[3];
  bit         m_ext;
  bit         m_brk;
  int         m_pause;

  function automatic int joy_index(bit ext, logic [7:0] code);
    if (ext) begin
      case (code)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end
    case (code)
      8'h29: return 4;
      8'h16: return 5;
      8'h1E: return 6;
      8'h2E: return 7;
      8'h11: return 8;
      default: return -1;
    endcase
  endfunction

  function automatic int hot_index(bit ext, logic [7:0] code);
    if (ext) return -1;
    case (code)
      8'h06: return 0;
      8'h04: return 1;
      8'h07: return 2;
      default: return -1;
    endcase
  endfunction

  task model_reset();
    m_joy = '0;
    m_sd = INIT;
    m_sl = 2'd0;
    for (int i = 0; i < 3; i++) m_held[i] = 0;
    m_ext = 0;
    m_brk = 0;
    m_pause = 0;
  endtask

  task model_key(input logic [7:0] code, input bit ext, input bit brk, output bit reload);
    int ji;
    int hi;
    reload = 0;
    ji = joy_index(ext, code);
    hi = hot_index(ext, code);
    if (ji >= 0) m_joy[ji] = !brk;
    if (hi >= 0) begin
      if (brk) begin
        m_held[hi] = 0;
      end else if (!m_held[hi]) begin
        m_held[hi] = 1;
        if (hi == 0) m_sd = ~m_sd;
        else if (hi == 1) m_sl = m_sl + 2'd1;
        else reload = 1;
      end
    end
  endtask

  task model_byte(input logic [7:0] b);
    exp_t e;
    bit rl;
    rl = 0;
    if (m_pause > 0) begin
      m_pause--;
    end else if (m_brk) begin
      model_key(b, m_ext, 1, rl);
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hE1 && !m_ext) begin
      m_pause = 7;
    end else begin
      model_key(b, m_ext, 0, rl);
      m_ext = 0;
    end
    e.code = b;
    e.joy = m_joy;
    e.sd = m_sd;
    e.sl = m_sl;
    e.reload = rl;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; leaves at posedge+1.
  task send_byte(input logic [7:0] b, input int hold, input int gap);
    model_byte(b);
    kbd_scancode = b;
    kbd_intr = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    kbd_intr = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task sb(input logic [7:0] b);
    send_byte(b, 1, 2);
  endtask

  task do_reset(input int n);
    reset = 1'b1;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task chk(input string name, input logic [7:0] code, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (byte %h): got %h expected %h", name, code, act, req);
    end
  endtask

  // Monitor: an event is a rising kbd_intr seen at a non-reset edge.
  initial begin
    bit   prev;
    bit   ev;
    bit   rs;
    bit   have;
    bit   started;
    int   since;
    exp_t e;
    prev = 0;
    started = 0;
    since = 0;
    forever begin
      @(posedge clk);
      ev = !reset && kbd_intr && !prev;
      prev = kbd_intr;
      rs = reset;
      have = 0;
      if (rs) begin
        started = 1;
        since = 0;
      end else begin
        since++;
      end
      if (ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL event_without_expectation: got byte %h expected no event", kbd_scancode);
        end else begin
          e = exp_q.pop_front();
          have = 1;
          if (e.reload) since = 0;
        end
      end
      @(negedge clk);
      if (started) chk("rst_core", 8'h00, {15'd0, rst_core_o}, {15'd0, since < HOLD});
      if (have) begin
        chk("joy", e.code, {7'd0, joyBCPPFRLDU}, {7'd0, e.joy});
        chk("scandbl", e.code, {15'd0, scandoubler_disable_o}, {15'd0, e.sd});
        chk("scanlines", e.code, {14'd0, scanlines_o}, {14'd0, e.sl});
      end
      if (rs) begin
        chk("reset_joy", 8'h00, {7'd0, joyBCPPFRLDU}, 16'd0);
        chk("reset_scandbl", 8'h00, {15'd0, scandoubler_disable_o}, {15'd0, INIT});
        chk("reset_scanlines", 8'h00, {14'd0, scanlines_o}, 16'd0);
      end
    end
  end

  logic [7:0] pool [20];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h16, 8'h1E,
             8'h2E, 8'h11, 8'h06, 8'h04, 8'h07, 8'hAA, 8'h12, 8'h59, 8'hFA, 8'hF0};
    model_reset();
    #1;
    do_reset(1);
    idle(20);

    // Extended arrow make/break, and keypad 8 without E0.
    sb(8'hE0); sb(8'h75);
    sb(8'hE0); sb(8'hF0); sb(8'h75);
    sb(8'h75);

    // Plain keys, then a long strobe on '2'.
    sb(8'h29); sb(8'h2E); sb(8'h16);
    sb(8'hF0); sb(8'h2E);
    send_byte(8'h1E, 5, 2);

    // Scanline hotkey wraps, scandoubler toggle ignores repeats.
    for (int i = 0; i < 4; i++) begin
      sb(8'h04); sb(8'hF0); sb(8'h04);
    end
    sb(8'h06); sb(8'h06); sb(8'h06);
    sb(8'hF0); sb(8'h06); sb(8'h06);

    // Pause sequence is skipped entirely.
    sb(8'hE1); sb(8'h14); sb(8'h77); sb(8'hE1); sb(8'hF0); sb(8'h14); sb(8'hF0); sb(8'h77);
    sb(8'h29);

    // Reset hotkey with reload while still counting.
    sb(8'h07);
    idle(10);
    sb(8'hF0); sb(8'h07); sb(8'h07);
    idle(24);

    // Reset after a prefix discards it.
    sb(8'hE0);
    do_reset(1);
    idle(2);
    sb(8'h29);

    // Strobe already high across reset release produces no event.
    kbd_scancode = 8'h29;
    kbd_intr = 1'b1;
    reset = 1'b1;
    model_reset();
    idle(1);
    reset = 1'b0;
    idle(3);
    kbd_intr = 1'b0;
    idle(2);
    sb(8'h16);
    idle(20);

    // Randomized byte stream with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($urandom_range(1, 3));
        idle(1);
      end
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 4), $urandom_range(1, 3));
      end else begin
        send_byte(pool[$urandom_range(0, 19)], $urandom_range(1, 4), $urandom_range(1, 3));
      end
    end
    idle(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unconsumed expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
